// File: rtl/seq_divider.sv
// seq_divider: sequential signed two's-complement divider (restoring algorithm).
// The magnitudes are divided one quotient bit per clock, and the signs are applied
// in a final correction pass.
// Quotient truncates toward zero. The remainder takes the sign of the dividend.
// Optional build macro: DIV_EARLY_EXIT_EN. When it is defined, an operation with
// |dividend| < |divisor| skips the iterations and completes one edge after start.
//
// Handshake: start, dividend and divisor are sampled on a rising edge only when
// busy is low (state IDLE). That edge accepts the operation, and busy rises in the
// next cycle. A start seen while busy is high is ignored. done is a single-cycle
// pulse in the first IDLE cycle after the operation. The results are valid from
// that cycle and hold until the next completion. Because start is honoured in the
// done cycle, operations can run back to back.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam int               CNT_W   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t             r_state;
    state_t             w_next;

    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign_dd;
    logic               r_sign_dv;
    logic [WIDTH-1:0]   r_abs_dv;
    logic [WIDTH-1:0]   r_dd_orig;
    logic               r_dv_zero;
    logic [WIDTH:0]     r_prem;
    logic [WIDTH-1:0]   r_qreg;

    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_zero;

    logic [WIDTH-1:0]   w_abs_dd;
    logic [WIDTH-1:0]   w_abs_dv;
    logic               w_dv_zero;
    logic               w_early;
    logic [2*WIDTH:0]   w_cat;
    logic [WIDTH+1:0]   w_trial;
    logic               w_fit;
    logic [WIDTH-1:0]   w_neg_q;
    logic [WIDTH-1:0]   w_neg_r;

    // Operand magnitudes as unsigned values. The most negative value maps to 2^(WIDTH-1).
    assign w_abs_dd  = dividend[WIDTH-1] ? (~dividend + ONE) : dividend;
    assign w_abs_dv  = divisor[WIDTH-1]  ? (~divisor + ONE)  : divisor;
    assign w_dv_zero = (divisor == '0);

`ifdef DIV_EARLY_EXIT_EN
    // The quotient is trivially zero when the dividend magnitude is below the divisor.
    assign w_early = !w_dv_zero && (w_abs_dd < w_abs_dv);
`else
    assign w_early = 1'b0;
`endif

    // One restoring step: shift {prem, qreg} left, then trial-subtract the divisor.
    // The partial remainder stays below |divisor|, so bit WIDTH of r_prem always shifts out as zero.
    assign w_cat   = {r_prem, r_qreg} << 1;
    assign w_trial = {1'b0, w_cat[2*WIDTH:WIDTH]} - {2'b00, r_abs_dv};
    assign w_fit   = ~w_trial[WIDTH+1];

    // Sign correction values used in the FIX pass.
    assign w_neg_q = ~r_qreg + ONE;
    assign w_neg_r = ~r_prem[WIDTH-1:0] + ONE;

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_zero    = r_div_zero;
    assign o_dbg_state = r_state;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection: IDLE -> CALC (or FIX on a zero divisor or an early exit),
    // CALC for WIDTH iterations, then FIX for one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_dv_zero || w_early) begin
                        w_next = S_FIX;
                    end else begin
                        w_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (r_cnt == CNT_LAST) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture in IDLE, iteration in CALC, and result publication in FIX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_sign_dd   <= 1'b0;
            r_sign_dv   <= 1'b0;
            r_abs_dv    <= '0;
            r_dd_orig   <= '0;
            r_dv_zero   <= 1'b0;
            r_prem      <= '0;
            r_qreg      <= '0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sign_dd <= dividend[WIDTH-1];
                        r_sign_dv <= divisor[WIDTH-1];
                        r_abs_dv  <= w_abs_dv;
                        r_dd_orig <= dividend;
                        r_dv_zero <= w_dv_zero;
                        r_cnt     <= '0;
                        if (w_early) begin
                            r_qreg <= '0;
                            r_prem <= {1'b0, w_abs_dd};
                        end else begin
                            r_qreg <= w_abs_dd;
                            r_prem <= '0;
                        end
                    end
                end
                S_CALC: begin
                    r_prem <= w_fit ? w_trial[WIDTH:0] : w_cat[2*WIDTH:WIDTH];
                    r_qreg <= w_cat[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, w_fit};
                    r_cnt  <= r_cnt + CNT_ONE;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (r_dv_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= r_dd_orig;
                        r_div_zero  <= 1'b1;
                    end else begin
                        // Most negative / -1 wraps to the most negative value through the negation.
                        r_quotient  <= (r_sign_dd ^ r_sign_dv) ? w_neg_q : r_qreg;
                        r_remainder <= r_sign_dd ? w_neg_r : r_prem[WIDTH-1:0];
                        r_div_zero  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed bench for seq_divider, checked against
// a plain-arithmetic reference model through a scoreboard queue.
module tb_seq_divider;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;
  logic [1:0]   dbg_state;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_zero   (div_zero),
    .o_dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int done_cnt = 0;
  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [2*W:0] exp_q[$];   // {div_zero, quotient, remainder}
  logic [2*W:0] last_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference: signed integer division truncating toward zero, with the
  // remainder taking the dividend's sign. The W-bit truncation produces the wrap for MIN/-1.
  function automatic logic [2*W:0] model(input logic [W-1:0] dd, input logic [W-1:0] dv);
    longint a, b, q, r;
    a = $signed(dd);
    b = $signed(dv);
    if (b == 0) return {1'b1, {W{1'b1}}, dd};
    q = a / b;
    r = a % b;
    return {1'b0, q[W-1:0], r[W-1:0]};
  endfunction

  function automatic int exp_lat(input logic [W-1:0] dd, input logic [W-1:0] dv);
    longint a, b;
    a = $signed(dd);
    b = $signed(dv);
    if (b == 0) return 1;
`ifdef DIV_EARLY_EXIT_EN
    if (((a < 0) ? -a : a) < ((b < 0) ? -b : b)) return 1;
`endif
    return W + 1;
  endfunction

  // ---------------- driver ----------------
  // chained=1: the caller is already in the previous done cycle (#1 after the edge).
  task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv, input bit chained);
    int edges;
    int busy_cycles;
    int lat;
    bit seen;
    logic [2*W:0] exp;
    exp_q.push_back(model(dd, dv));
    lat = exp_lat(dd, dv);
    if (!chained) @(negedge clk);
    start = 1'b1;
    dividend = dd;
    divisor = dv;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
    check("done_low_after_start", {31'd0, done}, 32'd0);
    edges = 0;
    busy_cycles = 0;
    seen = 1'b0;
    while (!seen && edges < 3 * W) begin
      if (busy === 1'b1) busy_cycles++;
      @(posedge clk);
      #1;
      edges++;
      seen = (done === 1'b1);
    end
    exp = exp_q.pop_front();
    last_exp = exp;
    check("done_seen", {31'd0, seen}, 32'd1);
    check("latency", edges, lat);
    check("busy_cycles", busy_cycles, lat);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    check("quotient", {16'd0, quotient}, {16'd0, exp[2*W-1:W]});
    check("remainder", {16'd0, remainder}, {16'd0, exp[W-1:0]});
    check("div_zero", {31'd0, div_zero}, {31'd0, exp[2*W]});
  endtask

  // ---------------- stimulus ----------------
  int done_before;
  int mode;
  logic [W-1:0] rdd;
  logic [W-1:0] rdv;

  initial begin
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", {16'd0, quotient}, 32'd0);
    check("rst_remainder", {16'd0, remainder}, 32'd0);
    check("rst_div_zero", {31'd0, div_zero}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases.
    run_op(16'd100, 16'd7, 1'b0);
    check("q_100_7_const", {16'd0, quotient}, 32'd14);
    check("r_100_7_const", {16'd0, remainder}, 32'd2);
    run_op(16'hFF9C, 16'd7, 1'b0);
    check("q_m100_7_const", {16'd0, quotient}, 32'h0000FFF2);
    check("r_m100_7_const", {16'd0, remainder}, 32'h0000FFFE);
    run_op(16'd100, 16'hFFF9, 1'b0);
    run_op(16'h8000, 16'hFFFF, 1'b0);
    check("q_overflow_const", {16'd0, quotient}, 32'h00008000);
    run_op(16'h8000, 16'd1, 1'b0);
    run_op(16'd5, 16'd0, 1'b0);
    run_op(16'd9, 16'd3, 1'b0);

    // Results hold while idle, and done stays low.
    repeat (5) @(posedge clk);
    #1;
    check("hold_quotient", {16'd0, quotient}, {16'd0, last_exp[2*W-1:W]});
    check("hold_remainder", {16'd0, remainder}, {16'd0, last_exp[W-1:0]});
    check("hold_done_low", {31'd0, done}, 32'd0);

    // Abort: 1000/10, an ignored start at edge 5, and reset near edge 10.
    done_before = done_cnt;
    @(negedge clk);
    start = 1'b1;
    dividend = 16'd1000;
    divisor = 16'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    dividend = 16'd7;
    divisor = 16'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_mid_op", {31'd0, busy}, 32'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_quotient", {16'd0, quotient}, 32'd0);
    check("abort_remainder", {16'd0, remainder}, 32'd0);
    check("abort_div_zero", {31'd0, div_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, done_before);
    run_op(16'd1000, 16'd10, 1'b0);

    // Back-to-back: the second start is driven in the done cycle of the first operation.
    run_op(16'd100, 16'd7, 1'b0);
    run_op(16'd3, 16'd5, 1'b1);

    // Randomized operations, including the special cases.
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 5);
      rdd = W'($urandom);
      rdv = W'($urandom);
      case (mode)
        0: rdv = '0;
        1: begin rdd = 16'h8000; rdv = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0001; end
        2: begin
          rdv = W'($urandom_range(1, 9));
          if ($urandom_range(0, 1) == 1) rdv = ~rdv + 16'd1;
        end
        3: begin
          rdv = W'($urandom_range(100, 30000));
          rdd = W'($urandom_range(0, 99));
          if ($urandom_range(0, 1) == 1) rdd = ~rdd + 16'd1;
        end
        default: ;
      endcase
      run_op(rdd, rdv, ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential signed two's-complement divider. It is the inverse companion of the team's sequential Booth multiplier datapath.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor using restoring division, one quotient bit per clock.
- Uses a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic unit, driven by the same controller.

Parameters:
- WIDTH, 16, operand/result width in bits (must be >= 2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  signed dividend; sampled with start.
- divisor  input  WIDTH  signed divisor; sampled with start.
- busy  output  1  high while a division is in progress (any state other than IDLE).
- done  output  1  one-cycle pulse; results valid from this cycle on.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; sign follows dividend.
- div_zero  output  1  set with done when divisor was 0; held with the results.

Behaviour:
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_zero=0, state=IDLE, iteration counter=0. Operand registers are cleared.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at an edge:
  - Latch the sign of dividend, the sign of divisor, |dividend| and |divisor| as WIDTH-bit unsigned values (|0x8000| = 32768 for WIDTH=16).
  - Clear the partial remainder (WIDTH+1 bits), load the quotient shift register with |dividend|, clear the counter.
  - Next state is CALC, or FIX if divisor==0.
- CALC, each edge:
  - Shift {prem, qreg} left by 1.
  - Compute trial = shifted prem - {0,|divisor|}.
  - If trial >= 0: prem = trial and qreg[0] = 1; else keep the shifted prem and qreg[0] = 0.
  - Increment the counter. After the WIDTH-th iteration (counter == WIDTH-1), go to FIX.
- FIX, one edge (sign correction):
  - quotient = qreg negated if the dividend and divisor signs differ.
  - remainder = prem[WIDTH-1:0] negated if the dividend was negative.
  - Assert done for exactly one cycle; go to IDLE.
- Divide-by-zero path (FIX entered from IDLE): quotient = all ones, remainder = original dividend, div_zero = 1. No CALC cycles.
- Latency:
  - Normal division: done is high in the cycle following the (WIDTH+1)-th edge after the start edge (17 edges for WIDTH=16).
  - Divide by zero: done follows the 1st edge after the start edge.
- Overflow (most negative value / -1): the result wraps to quotient = 0x8000, remainder = 0. div_zero = 0; no separate flag.
- Result hold: quotient, remainder and div_zero hold until the next FIX. div_zero clears at the next non-zero-divisor completion.
- Handshake:
  - busy = (state != IDLE).
  - start while busy is ignored. Operand changes after acceptance have no effect.
  - start asserted in the done cycle (state IDLE) is accepted. Back-to-back operation is allowed.
- Reset asserted mid-operation: immediate return to reset values. No done is produced for the aborted operation.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined: in IDLE, if the divisor is non-zero and |dividend| < |divisor| (this includes dividend==0), go directly to FIX with qreg = 0 and prem = |dividend|.
  - Result: quotient = 0, remainder = dividend.
  - done follows the 1st edge after the start edge.
- Not defined: all non-zero-divisor operations take the full WIDTH+1 edges. Results are identical either way; only latency differs.

Test Plan:
- dividend=100, divisor=7, start one cycle -> done after 17 edges; quotient=14, remainder=2, div_zero=0, busy high for exactly 17 cycles.
- dividend=-100 (0xFF9C), divisor=7 -> quotient=0xFFF2 (-14), remainder=0xFFFE (-2). Also dividend=100, divisor=-7 -> quotient=0xFFF2, remainder=2.
- dividend=0x8000, divisor=0xFFFF -> quotient=0x8000, remainder=0; dividend=0x8000, divisor=1 -> quotient=0x8000, remainder=0.
- dividend=5, divisor=0 -> done after 1 edge; quotient=0xFFFF, remainder=5, div_zero=1. Next op 9/3 -> quotient=3, remainder=0, div_zero=0.
- Start 1000/10, pulse start with 7/7 at edge 5 (ignored), assert rst at edge 10 -> all outputs 0, no done. Then 1000/10 -> quotient=100, remainder=0.
- Back-to-back: start asserted in the done cycle with 3/5 -> accepted. With DIV_EARLY_EXIT_EN: done after 1 edge, quotient=0, remainder=3. Without it: done after 17 edges, same result.
